baud_rate_gen_frac: RTL and testbench



---
 rtl/baud_rate_gen_frac.sv | 89 ++++++++
 tb/tb_baud_rate_gen_frac.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/baud_rate_gen_frac.sv
// baud_rate_gen_frac: fractional baud tick generator producing oversample and per-bit ticks.
// Divisor changes take effect only at a period boundary, or immediately while disabled.
module baud_rate_gen_frac #(
    parameter int N        = 16,
    parameter int F        = 4,
    parameter int OVS      = 16,
    parameter int DEF_INT  = 163,
    parameter int DEF_FRAC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] div_int,
    input  logic [F-1:0] div_frac,
    output logic         s_tick,
    output logic         bit_tick,
    output logic         cfg_err,
    output logic [N-1:0] cur_int,
    output logic [F-1:0] cur_frac
);
    localparam int OW = OVS > 1 ? $clog2(OVS) : 1;

    logic [N:0]    cnt, plen;
    logic [F-1:0]  acc, pend_frac, nxt_frac;
    logic [N-1:0]  pend_int, nxt_int;
    logic [OW-1:0] ovs_cnt;
    logic [F:0]    acc_sum;
    logic          pend_valid, legal, ovs_last, nxt_valid;

    assign legal    = load && div_int > N'(1);
    assign ovs_last = ovs_cnt == OW'(OVS - 1);
    assign s_tick   = en && !reset && !clear && cnt == plen - (N+1)'(1);
    assign bit_tick = s_tick && ovs_last;
    assign acc_sum  = {1'b0, acc} + {1'b0, cur_frac};
    // a legal load arriving on a boundary cycle wins over an older pending value
    assign nxt_valid = legal || pend_valid;
    assign nxt_int   = legal ? div_int : pend_int;
    assign nxt_frac  = legal ? div_frac : pend_frac;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            ovs_cnt    <= '0;
            plen       <= (N+1)'(DEF_INT);
            cur_int    <= N'(DEF_INT);
            cur_frac   <= F'(DEF_FRAC);
            pend_int   <= '0;
            pend_frac  <= '0;
            pend_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= load && !legal;
            if (clear || (legal && !en)) begin
                cnt        <= '0;
                acc        <= '0;
                ovs_cnt    <= '0;
                pend_valid <= 1'b0;
                cur_int    <= nxt_valid ? nxt_int : cur_int;
                cur_frac   <= nxt_valid ? nxt_frac : cur_frac;
                plen       <= {1'b0, nxt_valid ? nxt_int : cur_int};
            end else if (en) begin
                if (s_tick) begin
                    cnt        <= '0;
                    ovs_cnt    <= ovs_last ? '0 : ovs_cnt + OW'(1);
                    pend_valid <= 1'b0;
                    if (nxt_valid) begin
                        cur_int  <= nxt_int;
                        cur_frac <= nxt_frac;
                        acc      <= '0;
                        plen     <= {1'b0, nxt_int};
                    end else begin
                        acc  <= acc_sum[F-1:0];
                        plen <= {1'b0, cur_int} + (N+1)'(acc_sum[F]);
                    end
                end else begin
                    cnt <= cnt + (N+1)'(1);
                    if (legal) begin
                        pend_int   <= div_int;
                        pend_frac  <= div_frac;
                        pend_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// tb_baud_rate_gen_frac: directed test-plan scenarios plus random traffic, checked every
// cycle against a period-index model where period j lasts int + floor(j*frac/2^F) - floor((j-1)*frac/2^F).
module tb_baud_rate_gen_frac;
    localparam int N = 16, F = 4, OVS = 16, DEF_INT = 163, DEF_FRAC = 0;

    logic         clk = 1'b0, reset = 1'b1, en = 1'b0, clear = 1'b0, load = 1'b0;
    logic [N-1:0] div_int = '0;
    logic [F-1:0] div_frac = '0;
    logic         s_tick, bit_tick, cfg_err;
    logic [N-1:0] cur_int;
    logic [F-1:0] cur_frac;

    int tests = 0, fails = 0;
    int m_int, m_frac, p_int, p_frac, per, el, nt;
    bit p_v, m_cfg, armed = 0;
    int cyc, first_s, first_b, ticks, bits;

    always #5 clk = ~clk;

    baud_rate_gen_frac #(.N(N), .F(F), .OVS(OVS), .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
        .div_int(div_int), .div_frac(div_frac), .s_tick(s_tick), .bit_tick(bit_tick),
        .cfg_err(cfg_err), .cur_int(cur_int), .cur_frac(cur_frac)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int plen_of(int j);
        return j == 0 ? m_int : m_int + (j * m_frac) / (1 << F) - ((j - 1) * m_frac) / (1 << F);
    endfunction

    task automatic step(input bit r, input bit e, input bit c, input bit l, input int di, input int df);
        bit exp_tick, lg;
        @(negedge clk);
        reset = r; en = e; clear = c; load = l; div_int = N'(di); div_frac = F'(df);
        #1;
        exp_tick = !r && e && !c && armed && (el + 1 == plen_of(per));
        check("s_tick", 32'(s_tick), 32'(exp_tick));
        check("bit_tick", 32'(bit_tick), 32'(exp_tick && nt == OVS - 1));
        if (armed) begin
            check("cfg_err", 32'(cfg_err), 32'(m_cfg));
            check("cur_int", 32'(cur_int), 32'(m_int));
            check("cur_frac", 32'(cur_frac), 32'(m_frac));
        end
        if (r) begin
            m_int = DEF_INT; m_frac = DEF_FRAC; p_v = 0; per = 0; el = 0; nt = 0; m_cfg = 0; armed = 1;
        end else begin
            lg = l && di >= 2;
            m_cfg = l && di < 2;
            if (c || (lg && !e)) begin
                if (lg) begin m_int = di; m_frac = df; end
                else if (p_v) begin m_int = p_int; m_frac = p_frac; end
                per = 0; el = 0; nt = 0; p_v = 0;
            end else if (e) begin
                if (exp_tick) begin
                    nt = (nt + 1) % OVS; el = 0;
                    if (lg) begin m_int = di; m_frac = df; per = 0; end
                    else if (p_v) begin m_int = p_int; m_frac = p_frac; per = 0; end
                    else per++;
                    p_v = 0;
                end else begin
                    el++;
                    if (lg) begin p_v = 1; p_int = di; p_frac = df; end
                end
            end
        end
    endtask

    initial begin
        repeat (2) step(1, 0, 0, 0, 0, 0);
        // defaults: first s_tick on cycle 163, first bit_tick on cycle 2608
        cyc = 0; first_s = 0; first_b = 0;
        repeat (2700) begin
            step(0, 1, 0, 0, 0, 0);
            cyc++;
            if (s_tick && first_s == 0) first_s = cyc;
            if (bit_tick && first_b == 0) first_b = cyc;
        end
        check("first_s_tick_cycle", first_s, 163);
        check("first_bit_tick_cycle", first_b, 2608);
        // fractional 10 + 8/16 loaded while disabled
        step(0, 0, 0, 1, 10, 8);
        cyc = 0; ticks = 0; bits = 0;
        while (ticks < 32 && cyc < 400) begin
            step(0, 1, 0, 0, 0, 0);
            cyc++;
            if (s_tick) ticks++;
            if (bit_tick) bits++;
        end
        check("32_periods_cycles", cyc, 335);
        check("bit_ticks_in_32", bits, 2);
        // load 20/0 on cycle 50 of a default period: that period still ends at 163
        step(1, 0, 0, 0, 0, 0);
        repeat (49) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 20, 0);
        cyc = 50; first_s = 0;
        while (first_s == 0 && cyc < 300) begin
            step(0, 1, 0, 0, 0, 0);
            cyc++;
            if (s_tick) first_s = cyc;
        end
        check("boundary_period", first_s, 163);
        cyc = 0; first_s = 0;
        while (first_s == 0 && cyc < 100) begin
            step(0, 1, 0, 0, 0, 0);
            cyc++;
            if (s_tick) first_s = cyc;
        end
        check("new_period", first_s, 20);
        // illegal load pulses cfg_err once and leaves the divisor alone
        step(0, 1, 0, 1, 1, 3);
        step(0, 1, 0, 0, 0, 0);
        check("cfg_err_pulse", 32'(cfg_err), 1);
        check("cur_int_kept", 32'(cur_int), 20);
        step(0, 1, 0, 0, 0, 0);
        check("cfg_err_single", 32'(cfg_err), 0);
        // enable dropped for 7 cycles mid-period, then a clear mid-period
        repeat (5) step(0, 1, 0, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0, 0, 0);
        repeat (40) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        cyc = 0; first_s = 0;
        while (first_s == 0 && cyc < 100) begin
            step(0, 1, 0, 0, 0, 0);
            cyc++;
            if (s_tick) first_s = cyc;
        end
        check("after_clear", first_s, 20);
        // pending load discarded by reset
        repeat (3) step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 7, 5);
        step(1, 1, 0, 0, 0, 0);
        repeat (170) step(0, 1, 0, 0, 0, 0);
        check("pending_discarded", 32'(cur_int), DEF_INT);
        // random traffic with small divisors
        step(0, 0, 0, 1, 5, 3);
        repeat (6000)
            step($urandom % 600 == 0, $urandom % 8 != 0, $urandom % 120 == 0,
                 $urandom % 50 == 0, int'($urandom_range(0, 12)), int'($urandom % 16));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
